// File: rtl/sel_reduce_pkg.sv
// Shared types and width helpers for the sel_reduce_reg block.
// An entry is packed as {mode, a, b}.
package sel_reduce_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_HOLD = 2'b10,
    MODE_SET  = 2'b11
  } mode_e;

  localparam int MODE_W = 2;

  function automatic int entry_w(input int w);
    return MODE_W + 2 * w;
  endfunction

endpackage

// File: rtl/sel_reduce_fifo2.sv
// Two-entry in-order FIFO with push/pop, occupancy, full and empty flags.
// A push while full and a pop while empty are ignored.
module sel_reduce_fifo2 #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [1:0]   occupancy,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign occupancy = count;
  assign head      = mem[rd_ptr];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sel_reduce_reg.sv
// Reduces NCH channels per mode into an (a, b) pair and buffers results
// in a 2-entry FIFO; b_hold carries the previous accepted out_b forward.
module sel_reduce_reg
  import sel_reduce_pkg::*;
#(
  parameter int W     = 8,
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [NCH*W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int EW = entry_w(W);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and data is held stable while valid && !ready.
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    fifo_occ;
  logic [EW-1:0] fifo_head;
  logic [EW-1:0] new_entry;
  logic [W-1:0]  b_hold;
  logic [W-1:0]  and_all;
  logic [W-1:0]  or_all;
  logic [W-1:0]  calc_a;
  logic [W-1:0]  calc_b;
  mode_e         mode;

  assign mode      = mode_e'(in_mode);
  assign in_ready  = !fifo_full && !rst;
  assign push      = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    and_all = '1;
    or_all  = '0;
    calc_a  = '0;
    calc_b  = '0;
    for (int i = 0; i < NCH; i++) begin
      and_all = and_all & in_data[i*W +: W];
      or_all  = or_all | in_data[i*W +: W];
    end
    case (mode)
      MODE_AND:  calc_a = and_all;
      MODE_OR:   calc_b = or_all;
      MODE_HOLD: calc_b = b_hold;
      MODE_SET:  calc_a = '1;
      default: begin
        calc_a = '0;
        calc_b = '0;
      end
    endcase
  end

  assign new_entry = {in_mode, calc_a, calc_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      b_hold  <= '0;
      txn_cnt <= '0;
    end else begin
      // Loaded on every accepted transaction, so HOLD re-stores its own value.
      if (push) begin
        b_hold <= calc_b;
      end
      if (pop && (txn_cnt != {CNT_W{1'b1}})) begin
        txn_cnt <= txn_cnt + 1'b1;
      end
    end
  end

  sel_reduce_fifo2 #(
    .W(EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     (new_entry),
    .head      (fifo_head),
    .occupancy (fifo_occ),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_mode = fifo_empty ? 2'b00 : fifo_head[EW-1 -: 2];
  assign out_a    = fifo_empty ? '0 : fifo_head[2*W-1 -: W];
  assign out_b    = fifo_empty ? '0 : fifo_head[W-1:0];

endmodule

// File: tb/tb_sel_reduce_reg.sv
// Directed table plus corner-case sequences for sel_reduce_reg (W=8, NCH=4),
// with a second CNT_W=3 instance for counter saturation.
module tb_sel_reduce_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [1:0]  out_mode;
  logic [15:0] txn_cnt;

  logic        s_in_valid;
  logic        s_in_ready;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_out_a;
  logic [7:0]  s_out_b;
  logic [1:0]  s_out_mode;
  logic [2:0]  s_txn_cnt;

  int n_total = 0;
  int n_pass  = 0;

  logic [17:0] exp_q[$];

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  sel_reduce_reg #(.W(8), .NCH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_mode(out_mode), .txn_cnt(txn_cnt)
  );

  sel_reduce_reg #(.W(8), .NCH(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_mode(2'b11), .in_data(32'h0), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_a(s_out_a), .out_b(s_out_b),
    .out_mode(s_out_mode), .txn_cnt(s_txn_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [17:0] model(input logic [1:0] m, input logic [31:0] d,
                                        input logic [7:0] hold);
    logic [7:0] an;
    logic [7:0] orr;
    an  = 8'hFF;
    orr = 8'h00;
    for (int i = 0; i < 4; i++) begin
      an  = an & d[i*8 +: 8];
      orr = orr | d[i*8 +: 8];
    end
    case (m)
      2'b00:   return {m, an, 8'h00};
      2'b01:   return {m, 8'h00, orr};
      2'b10:   return {m, 8'h00, hold};
      default: return {m, 8'hFF, 8'h00};
    endcase
  endfunction

  task automatic send_one(input logic [1:0] m, input logic [31:0] d,
                          input logic [7:0] ea, input logic [7:0] eb);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = m;
    in_data   = d;
    #1;
    check("send_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("send_out_valid", {31'b0, out_valid}, 32'd1);
    check("send_out_a", {24'b0, out_a}, {24'b0, ea});
    check("send_out_b", {24'b0, out_b}, {24'b0, eb});
    check("send_out_mode", {30'b0, out_mode}, {30'b0, m});
    @(posedge clk); #1;
    check("send_drained", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [17:0] e;
    logic [7:0]  b_model;
    int          txn_model;
    int          max_occ;
    logic        hs_in;
    logic        hs_out;
    int          pushed;
    int          n_hs;

    vecs[0] = '{2'b00, 32'hF1F3FFF0, 8'hF0, 8'h00};
    vecs[1] = '{2'b01, 32'hF1F3FFF0, 8'h00, 8'hFF};
    vecs[2] = '{2'b10, 32'hF1F3FFF0, 8'h00, 8'hFF};
    vecs[3] = '{2'b11, 32'hF1F3FFF0, 8'hFF, 8'h00};
    vecs[4] = '{2'b10, 32'hF1F3FFF0, 8'h00, 8'h00};
    vecs[5] = '{2'b01, 32'h08040201, 8'h00, 8'h0F};
    vecs[6] = '{2'b10, 32'h08040201, 8'h00, 8'h0F};
    vecs[7] = '{2'b10, 32'h08040201, 8'h00, 8'h0F};
    vecs[8] = '{2'b00, 32'h08040201, 8'h00, 8'h00};
    vecs[9] = '{2'b10, 32'h08040201, 8'h00, 8'h00};

    rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_data = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_rst_outs", {14'b0, out_mode, out_a, out_b}, 32'd0);
    check("post_rst_txn", {16'b0, txn_cnt}, 32'd0);

    for (int i = 0; i < 10; i++)
      send_one(vecs[i].mode, vecs[i].data, vecs[i].exp_a, vecs[i].exp_b);

    // Backpressure: third offer must be refused, head must stay put.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_data = 32'hFFFFFF3C; #1;
    check("bp_ready0", {31'b0, in_ready}, 32'd1);
    exp_q.push_back({2'b00, 8'h3C, 8'h00});
    @(posedge clk); #1;
    in_mode = 2'b01; in_data = 32'h00001001; #1;
    check("bp_ready1", {31'b0, in_ready}, 32'd1);
    exp_q.push_back({2'b01, 8'h00, 8'h11});
    @(posedge clk); #1;
    in_mode = 2'b11; in_data = 32'h0; #1;
    check("bp_ready2_full", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_head_stable", {13'b0, out_valid, out_mode, out_a, out_b},
            {13'b0, 1'b1, exp_q[0]});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("bp_drain", {13'b0, out_valid, out_mode, out_a, out_b}, {13'b0, 1'b1, e});
      @(posedge clk); #1;
    end
    check("bp_empty", {31'b0, out_valid}, 32'd0);
    check("txn_before_rst", {16'b0, txn_cnt}, 32'd12);

    // Mid-stream reset with the FIFO full; the offer during reset is dropped.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b01; in_data = 32'h000000AA;
    repeat (2) @(posedge clk);
    #1;
    check("fill_full", {31'b0, in_ready}, 32'd0);
    rst = 1'b1; in_data = 32'h000000FF;
    @(posedge clk); #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_outs", {14'b0, out_mode, out_a, out_b}, 32'd0);
    check("midrst_txn", {16'b0, txn_cnt}, 32'd0);
    check("midrst_in_ready1", {31'b0, in_ready}, 32'd1);
    send_one(2'b10, 32'h12345678, 8'h00, 8'h00);

    // Random valid/ready against the scoreboard.
    b_model = 8'h00; txn_model = 1; max_occ = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_mode   = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("rnd_in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
      check("rnd_out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rnd_order", {14'b0, out_mode, out_a, out_b}, {14'b0, e});
        txn_model++;
      end
      if (hs_in) begin
        e = model(in_mode, in_data, b_model);
        b_model = e[7:0];
        exp_q.push_back(e);
      end
      if (exp_q.size() > max_occ) max_occ = exp_q.size();
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rnd_drain", {14'b0, out_mode, out_a, out_b}, {14'b0, e});
        txn_model++;
      end
      @(posedge clk); #1;
    end
    check("rnd_leftover", exp_q.size(), 32'd0);
    check("rnd_max_occ_le2", {31'b0, max_occ <= 2}, 32'd1);
    check("rnd_txn_cnt", {16'b0, txn_cnt}, txn_model);

    // Saturation on the 3-bit counter instance.
    s_out_ready = 1'b1; pushed = 0; n_hs = 0;
    for (int c = 0; c < 14; c++) begin
      s_in_valid = (pushed < 10);
      #1;
      hs_in  = s_in_valid && s_in_ready;
      hs_out = s_out_valid && s_out_ready;
      @(posedge clk); #1;
      if (hs_in) pushed++;
      if (hs_out) n_hs++;
      check("sat_cnt", {29'b0, s_txn_cnt}, (n_hs > 7) ? 32'd7 : n_hs);
    end
    s_in_valid = 1'b0;
    check("sat_handshakes", n_hs, 32'd10);
    check("sat_final", {29'b0, s_txn_cnt}, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sel_reduce_reg.md
# sel_reduce_reg

Parametrised, registered successor to the single-bit mode-select mux in the lint/synthesis examples. Takes NCH operand channels of W bits plus a 2-bit mode, reduces the channels per mode and delivers an (out_a, out_b) pair through a 2-entry valid/ready output buffer. Every output is fully assigned in every mode: no inferred latches. The former implicit "out_b keeps its value" mode is now an explicit hold register. The block sits between an operand source and a downstream consumer, and sustains one transaction per cycle.

## Interface
- W, default 8: data width per channel and per output.
- NCH, default 4: number of operand channels, minimum 2.
- CNT_W, default 16: width of the transaction counter.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: source presents a transaction.
- in_ready, output, 1: block accepts when in_valid && in_ready.
- in_mode, input, 2: operation select (00 AND, 01 OR, 10 HOLD, 11 SET).
- in_data, input, NCH*W: channel i is in_data[i*W +: W].
- out_valid, output, 1: head entry is valid.
- out_ready, input, 1: consumer takes the head when out_valid && out_ready.
- out_a, output, W: result A of the head entry.
- out_b, output, W: result B of the head entry.
- out_mode, output, 2: mode of the head entry.
- txn_cnt, output, CNT_W: count of completed output handshakes, saturating.

## Operation
- Results per mode are computed from the accepted transaction:
  - AND: out_a = bitwise AND of all NCH channels; out_b = 0.
  - OR: out_a = 0; out_b = bitwise OR of all NCH channels.
  - HOLD: out_a = 0; out_b = b_hold.
  - SET: out_a = all ones; out_b = 0.
- b_hold (W bits) loads the out_b value computed for every accepted transaction, whatever its mode. In HOLD mode this reloads the same value.
- The computed {mode, a, b} is pushed into a 2-entry in-order FIFO. The head of the FIFO drives out_a, out_b and out_mode.
- When out_valid = 0, out_a, out_b and out_mode read 0.
- in_ready = (occupancy < 2) && !rst.
- txn_cnt increments on each output handshake and saturates at 2^CNT_W - 1.
- Reset clears the FIFO, occupancy, b_hold and txn_cnt. A transaction presented during a reset cycle is dropped.

## Timing
- Reset values: out_valid 0, out_a 0, out_b 0, out_mode 0, txn_cnt 0, in_ready 0 while rst is high. in_ready is 1 in the first cycle after rst deasserts.
- Latency: a transaction accepted at edge k appears on the outputs, with out_valid = 1, from cycle k+1 when the FIFO was empty.
- Throughput: 1 per cycle when out_ready is held high.
- Simultaneous push and pop:
  - Occupancy 1: occupancy stays 1 and the new entry becomes the head next cycle.
  - Occupancy 2: no push is possible because in_ready = 0; a pop frees one slot and in_ready = 1 next cycle.
- Full (occupancy 2): in_ready = 0 and in_valid is ignored.
- Empty: out_valid = 0 and out_ready is ignored.
- out_valid/out_a/out_b/out_mode stay stable while out_valid && !out_ready.
- b_hold uses the value from the preceding accepted transaction. Back-to-back OR then HOLD: the HOLD result equals the OR result.
- txn_cnt updates one cycle after the handshake edge (registered).

## Structure
- Package sel_reduce_pkg holds:
  - mode_e enum: MODE_AND = 2'b00, MODE_OR = 2'b01, MODE_HOLD = 2'b10, MODE_SET = 2'b11.
  - Parameterised entry struct {mode_e mode; a; b}, or equivalent width constants.
- Sub-module sel_reduce_fifo2: 2-entry, W-generic FIFO with push/pop, occupancy, full and empty. It holds the only storage besides b_hold and txn_cnt.
- Reduction and mode decode are a single always_comb with default assignments first, so no path leaves an output unassigned.

## Test plan
- Reset: assert rst for 2 cycles mid-stream with FIFO full -> next cycle out_valid = 0, outputs 0, txn_cnt = 0, in_ready = 1; the next HOLD gives out_b = 0.
- Modes: W=8, NCH=4, channels {F0, FF, F3, F1}, out_ready = 1:
  - AND -> a = 0xF0, b = 0.
  - OR -> a = 0, b = 0xFF.
  - SET -> a = 0xFF, b = 0.
  - Each appears one cycle after acceptance.
- Hold chain: OR with {01, 02, 04, 08}, then HOLD, HOLD, AND, HOLD:
  - out_b sequence is 0x0F, 0x0F, 0x0F, 0x00, 0x00.
  - HOLD after AND gives 0 because AND loads b_hold = 0.
- Backpressure: out_ready = 0, offer 3 transactions -> 2 accepted, in_ready = 0 on the third. Head stays stable. Releasing out_ready drains in order with no loss or duplication.
- Concurrent push/pop at occupancy 1 with random valid/ready for 10k cycles -> output order matches the scoreboard and occupancy never exceeds 2.
- Saturation: CNT_W = 3, 10 handshakes -> txn_cnt reads 7 and holds.
